// File: rtl/fxp_pkg.sv
// Shared constants for the sign-magnitude fixed-point format and the accumulator FSM encoding.
package fxp_pkg;

  localparam int WORD_W   = 16;
  localparam int SIGN     = 15;
  localparam int INT_MSB  = 14;
  localparam int FRAC_MSB = 7;

  // Largest magnitude that fits in the 15 magnitude bits of a word.
  localparam logic [INT_MSB:0] MAG_MAX = '1;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/fxp_tc2sm_sat.sv
// Combinational conversion of a signed accumulator value into a saturated sign-magnitude word.
module fxp_tc2sm_sat
  import fxp_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic signed [ACC_W-1:0]  sum_i,
  output logic        [WORD_W-1:0] sm_o,
  output logic                     sat_o
);

  logic [ACC_W-1:0] mag;

  always_comb begin
    mag   = sum_i[ACC_W-1] ? ACC_W'(-sum_i) : ACC_W'(sum_i);
    sat_o = (mag > ACC_W'(MAG_MAX));
    // The sign bit comes straight from the sum, so a zero sum can never yield 0x8000.
    sm_o  = {sum_i[ACC_W-1], (sat_o ? MAG_MAX : mag[INT_MSB:0])};
  end

endmodule

// File: rtl/fxp_accumulator.sv
// Accumulates N_ACC sign-magnitude samples (or fewer on flush) and presents one saturated result.
module fxp_accumulator
  import fxp_pkg::*;
#(
  parameter int N_ACC = 4,
  parameter int ACC_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_sat
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in ACC, out_valid only in HOLD, and both depend only on state.

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic        [7:0]        cnt_q, cnt_d;
  logic        [WORD_W-1:0] out_data_q, out_data_d;
  logic                     out_sat_q, out_sat_d;

  logic                     accept;
  logic        [16:0]       mag17;
  logic signed [16:0]       sample_s;
  logic signed [ACC_W-1:0]  sum_next;
  logic        [WORD_W-1:0] sm_word;
  logic                     sm_sat;

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_HOLD);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  assign accept   = in_valid && in_ready;
  assign mag17    = {2'b00, in_data[INT_MSB:0]};
  assign sample_s = in_data[SIGN] ? -$signed(mag17) : $signed(mag17);
  // Sum including this cycle's sample, so the converter sees the final value before HOLD.
  assign sum_next = acc_q + (accept ? ACC_W'(sample_s) : '0);

  fxp_tc2sm_sat #(.ACC_W(ACC_W)) u_conv (
    .sum_i (sum_next),
    .sm_o  (sm_word),
    .sat_o (sm_sat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_ACC;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    case (state_q)
      ST_ACC: begin
        acc_d = sum_next;
        cnt_d = cnt_q + 8'(accept);
        if ((accept && (cnt_q == 8'(N_ACC - 1))) ||
            (flush && ((cnt_q != 8'd0) || accept))) begin
          state_d    = ST_HOLD;
          out_data_d = sm_word;
          out_sat_d  = sm_sat;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_ACC;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

endmodule

// File: tb/tb_fxp_accumulator.sv
// Self-checking bench for fxp_accumulator with N_ACC=4: vector table, corner sequences, random model.
module tb_fxp_accumulator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0000;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_sat;

  int total = 0;
  int bad = 0;

  logic [16:0] exp_q[$];

  fxp_accumulator #(.N_ACC(4), .ACC_W(24)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%05h expected 0x%05h", name, act, exp);
    end
  endtask

  // Reference model: signed integer sum of the samples, then clip and re-encode.
  function automatic logic [16:0] model(input logic [15:0] s[$]);
    int sum = 0;
    int mag;
    logic [15:0] word;
    logic sat;
    foreach (s[i]) begin
      mag = int'(s[i][14:0]);
      sum += s[i][15] ? -mag : mag;
    end
    mag = (sum < 0) ? -sum : sum;
    sat = (mag > 32767);
    if (sat) mag = 32767;
    word = {(sum < 0), mag[14:0]};
    return {sat, word};
  endfunction

  // ---------------- drivers ----------------
  // Called one step after a rising edge; returns one step after the accepting edge.
  task automatic push(input logic [15:0] d, input logic fl);
    int tmo = 0;
    in_valid = 1'b1;
    in_data  = d;
    flush    = fl;
    while (!in_ready && tmo < 50) begin
      tick();
      tmo++;
    end
    if (tmo >= 50) check("push_timeout", 17'd1, 17'd0);
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic collect(input string name, input int stall);
    int tmo = 0;
    logic [16:0] exp;
    while (!out_valid && tmo < 50) begin
      tick();
      tmo++;
    end
    if (tmo >= 50) begin
      check({name, "_timeout"}, 17'd1, 17'd0);
      return;
    end
    for (int i = 0; i < stall; i++) tick();
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1ffff;
    check(name, {out_sat, out_data}, exp);
    check({name, "_ready_in_hold"}, {16'd0, in_ready}, 17'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_ready_after"}, {16'd0, in_ready}, 17'd1);
  endtask

  typedef struct {
    logic [3:0][15:0] d;
    logic [15:0]      exp_data;
    logic             exp_sat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [15:0] samples[$];
    logic [15:0] held;

    vecs[0] = '{d: {16'h0040, 16'h8080, 16'h0200, 16'h0100}, exp_data: 16'h02C0, exp_sat: 1'b0};
    vecs[1] = '{d: {16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00}, exp_data: 16'h7FFF, exp_sat: 1'b1};
    vecs[2] = '{d: {16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00}, exp_data: 16'hFFFF, exp_sat: 1'b1};
    vecs[3] = '{d: {16'h0000, 16'h8000, 16'h8100, 16'h0100}, exp_data: 16'h0000, exp_sat: 1'b0};
    vecs[4] = '{d: {16'h8000, 16'h8000, 16'h8000, 16'h8000}, exp_data: 16'h0000, exp_sat: 1'b0};
    vecs[5] = '{d: {16'h8004, 16'h0001, 16'h0001, 16'h0001}, exp_data: 16'h8001, exp_sat: 1'b0};
    vecs[6] = '{d: {16'h0000, 16'h8000, 16'h3FFF, 16'h4000}, exp_data: 16'h7FFF, exp_sat: 1'b0};
    vecs[7] = '{d: {16'h0000, 16'h0000, 16'h4000, 16'h4000}, exp_data: 16'h7FFF, exp_sat: 1'b1};

    // Reset state
    tick();
    do_reset();
    check("reset_out", {out_sat, out_data}, 17'h00000);
    check("reset_valid", {16'd0, out_valid}, 17'd0);
    check("reset_ready", {16'd0, in_ready}, 17'd1);

    // Table-driven vectors, including one-cycle latency after the fourth accept
    foreach (vecs[v]) begin
      for (int k = 0; k < 4; k++) push(vecs[v].d[k], 1'b0);
      check($sformatf("vec%0d_latency", v), {16'd0, out_valid}, 17'd1);
      exp_q.push_back({vecs[v].exp_sat, vecs[v].exp_data});
      collect($sformatf("vec%0d", v), 0);
    end

    // Backpressure: HOLD with in_valid high for 5 cycles
    for (int k = 0; k < 4; k++) push(16'h0100, 1'b0);
    held = out_data;
    in_valid = 1'b1;
    in_data  = 16'h0100;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_stable", {out_sat, out_data}, {1'b0, held});
      check("bp_no_ready", {15'd0, in_ready, out_valid}, 17'd1);
    end
    check("bp_data", {out_sat, out_data}, 17'h00400);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_ready", {16'd0, in_ready}, 17'd1);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) push(16'h0040, 1'b0);
    exp_q.push_back(17'h001C0);
    collect("bp_next", 0);

    // Flush alone after two accepts
    push(16'h0100, 1'b0);
    push(16'h0100, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_latency", {16'd0, out_valid}, 17'd1);
    exp_q.push_back(17'h00200);
    collect("flush_two", 0);

    // Flush together with an accept
    push(16'h0100, 1'b0);
    push(16'h0080, 1'b1);
    exp_q.push_back(17'h00180);
    collect("flush_with_accept", 0);

    // Flush at count zero is ignored; the following group still needs four samples
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_zero_valid", {16'd0, out_valid}, 17'd0);
    tick();
    check("flush_zero_valid2", {15'd0, in_ready, out_valid}, 17'd2);
    for (int k = 0; k < 3; k++) push(16'h0010, 1'b0);
    check("flush_zero_count", {16'd0, out_valid}, 17'd0);
    push(16'h0010, 1'b0);
    exp_q.push_back(17'h00040);
    collect("flush_zero_group", 0);

    // Reset mid-accumulation discards the partial sum
    push(16'h0100, 1'b0);
    push(16'h0100, 1'b0);
    do_reset();
    check("rst_mid_valid", {15'd0, in_ready, out_valid}, 17'd2);
    for (int k = 0; k < 4; k++) push(16'h0040, 1'b0);
    exp_q.push_back(17'h00100);
    collect("rst_mid", 0);

    // Reset during HOLD discards the pending result
    for (int k = 0; k < 4; k++) push(16'h7F00, 1'b0);
    do_reset();
    check("rst_hold_out", {out_sat, out_data}, 17'h00000);
    check("rst_hold_valid", {15'd0, in_ready, out_valid}, 17'd2);

    // Randomized groups against the reference model
    for (int g = 0; g < 40; g++) begin
      int n;
      logic do_flush;
      samples.delete();
      do_flush = ($urandom_range(0, 3) == 0);
      n = do_flush ? $urandom_range(1, 3) : 4;
      for (int k = 0; k < n; k++) begin
        logic [15:0] s;
        s = ($urandom_range(0, 1) == 1) ? 16'($urandom) : {1'($urandom), 7'd0, 8'($urandom)};
        samples.push_back(s);
        for (int gap = $urandom_range(0, 2); gap > 0; gap--) tick();
        push(s, do_flush && (k == n - 1));
      end
      exp_q.push_back(model(samples));
      collect($sformatf("rand%0d", g), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fxp_accumulator.md
FXP_ACCUMULATOR -- requirements
Module: fxp_accumulator

Interface
REQ-001 Parameter N_ACC, default 4, sets samples per output result; legal range is 1..256.
REQ-002 Parameter ACC_W, default 24, sets the internal signed accumulator width; it SHALL be at least 17+ceil(log2(N_ACC)).
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-006 Port in_ready, output, 1 bit: block accepts in_data this cycle.
REQ-007 Port in_data, input, 16 bits: sign-magnitude fixed-point value, with sign in bit 15, integer in bits 14:8 and fraction in bits 7:0 (fixed_point_operation dout format).
REQ-008 Port flush, input, 1 bit: emit the partial sum early.
REQ-009 Port out_valid, output, 1 bit: out_data and out_sat are valid.
REQ-010 Port out_ready, input, 1 bit: consumer accepts the output.
REQ-011 Port out_data, output, 16 bits: accumulated result, in the same sign-magnitude format as in_data.
REQ-012 Port out_sat, output, 1 bit: out_data was clipped.

Function
REQ-013 An input handshake SHALL occur when in_valid and in_ready are both high; an output handshake SHALL occur when out_valid and out_ready are both high.
REQ-014 The FSM SHALL have two states, ACC and HOLD; in_ready SHALL be 1 only in ACC and out_valid SHALL be 1 only in HOLD.
REQ-015 Each accepted sample SHALL be converted to 17-bit two's complement (magnitude bits 14:0, negated when bit 15 is set) and added to the ACC_W accumulator; 0x8000 SHALL be treated as zero.
REQ-016 An 8-bit counter SHALL count accepted samples; on the N_ACC-th accept, the FSM SHALL go to HOLD at the next edge.
REQ-017 out_valid SHALL assert in the cycle after the final accept, giving one-cycle latency.
REQ-018 In ACC, flush high with count>0, or with an accept in the same cycle, SHALL go to HOLD at the next edge; any sample accepted in that cycle SHALL be included in the sum.
REQ-019 flush with count=0 and no accept SHALL be ignored.
REQ-020 flush in HOLD SHALL be ignored.
REQ-021 Before entering HOLD, the final sum SHALL be converted to sign-magnitude and registered into out_data and out_sat.
REQ-022 A magnitude above 0x7FFF SHALL clip to 0x7FFF with the sign preserved and out_sat=1; otherwise out_sat=0.
REQ-023 A zero sum SHALL output 0x0000, never 0x8000.
REQ-024 While in HOLD without an output handshake, out_data, out_sat and out_valid SHALL remain stable, and the block SHALL accept no input.
REQ-025 An output handshake SHALL clear the accumulator and counter and return the FSM to ACC; in_ready SHALL be 1 in the following cycle, not in the handshake cycle.
REQ-026 The accumulator SHALL NOT wrap for any legal N_ACC, since ACC_W is sized per REQ-002.

Reset
REQ-027 reset SHALL take priority over every other input.
REQ-028 On reset: state=ACC, accumulator=0, counter=0, out_valid=0, out_data=0x0000, out_sat=0, in_ready=1 from the next cycle.
REQ-029 Reset mid-accumulation or during HOLD SHALL discard the partial or pending result.

Structure
REQ-030 Package fxp_pkg SHALL hold SIGN=15, INT_MSB=14, FRAC_MSB=7, the 16-bit word width and the FSM state encoding.
REQ-031 The two's-complement to saturated sign-magnitude conversion SHALL be a sub-module fxp_tc2sm_sat (combinational, ACC_W in, 16-bit plus sat out).
REQ-032 The FSM, counter and accumulator SHALL stay in fxp_accumulator.

Verification
REQ-033 With N_ACC=4, inputs 0x0100, 0x0200, 0x8080, 0x0040 -> out_data=0x02C0 (2.75), out_sat=0, out_valid one cycle after the fourth accept.
REQ-034 Saturation: four inputs of 0x7F00 -> 0x7FFF with out_sat=1; four inputs of 0xFF00 -> 0xFFFF with out_sat=1.
REQ-035 Zero sum: inputs 0x0100, 0x8100, 0x8000, 0x0000 -> out_data=0x0000, out_sat=0.
REQ-036 Backpressure: out_ready held low for 5 cycles in HOLD with in_valid=1 -> out_data stable, in_ready=0, no sample consumed; the next result sums only the samples accepted after release.
REQ-037 Flush: accepts of 0x0100, 0x0100, then flush -> 0x0200; flush together with an accept of 0x0080 after one 0x0100 -> 0x0180; flush alone at count=0 -> no output.
REQ-038 Reset: reset after two accepts of 0x0100, then four inputs of 0x0040 -> 0x0100.
